// File: rtl/alu_preprocess_pipe.sv
// rtl/alu_preprocess_pipe.sv - registered ALU operand preprocessor with accumulator and 2-entry skid buffer
module alu_preprocess_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] amod,
    output logic [WIDTH-1:0] bmod,
    output logic             cin,
    output logic [3:0]       out_op,
    output logic             out_illegal,
    input  logic             res_valid,
    input  logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] acc
);

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

    logic [WIDTH-1:0] accsrc;
    logic [WIDTH-1:0] d_amod;
    logic [WIDTH-1:0] d_bmod;
    logic             d_cin;
    logic             d_ill;

    logic             s_valid;
    logic [WIDTH-1:0] s_amod;
    logic [WIDTH-1:0] s_bmod;
    logic             s_cin;
    logic [3:0]       s_op;
    logic             s_ill;

    logic accept;
    logic load_out;

    // A result written back in the same cycle as an ACC_* op is forwarded.
    assign accsrc   = res_valid ? res : acc;
    assign in_ready = !s_valid && !rst;
    assign accept   = in_valid && in_ready;
    assign load_out = !out_valid || out_ready;

    always_comb begin
        d_amod = '0;
        d_bmod = '0;
        d_cin  = 1'b0;
        d_ill  = 1'b0;
        casez (op)
            4'b0000: begin d_amod = '0;     d_bmod = a;      end
            4'b0001: begin d_amod = ONE;    d_bmod = ~a;     end
            4'b0010: begin d_amod = a;      d_bmod = b;      end
            4'b0011: begin d_amod = ONE;    d_bmod = a;      end
            4'b01??: begin d_amod = a;      d_bmod = b;      end
            4'b1000: begin d_amod = a;      d_bmod = ~b;     d_cin = 1'b1; end
            4'b1001: begin d_amod = a;      d_bmod = ONES;   end
            4'b1010: begin d_amod = accsrc; d_bmod = b;      end
            4'b1011: begin d_amod = accsrc; d_bmod = ~b;     d_cin = 1'b1; end
            default: d_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc         <= '0;
            out_valid   <= 1'b0;
            amod        <= '0;
            bmod        <= '0;
            cin         <= 1'b0;
            out_op      <= '0;
            out_illegal <= 1'b0;
            s_valid     <= 1'b0;
            s_amod      <= '0;
            s_bmod      <= '0;
            s_cin       <= 1'b0;
            s_op        <= '0;
            s_ill       <= 1'b0;
        end else begin
            if (res_valid)
                acc <= res;
            if (load_out) begin
                // The skid entry is older than anything arriving now, and
                // no input can be accepted while it is occupied.
                if (s_valid) begin
                    out_valid   <= 1'b1;
                    amod        <= s_amod;
                    bmod        <= s_bmod;
                    cin         <= s_cin;
                    out_op      <= s_op;
                    out_illegal <= s_ill;
                    s_valid     <= 1'b0;
                end else if (accept) begin
                    out_valid   <= 1'b1;
                    amod        <= d_amod;
                    bmod        <= d_bmod;
                    cin         <= d_cin;
                    out_op      <= op;
                    out_illegal <= d_ill;
                end else begin
                    out_valid   <= 1'b0;
                end
            end else if (accept) begin
                s_valid <= 1'b1;
                s_amod  <= d_amod;
                s_bmod  <= d_bmod;
                s_cin   <= d_cin;
                s_op    <= op;
                s_ill   <= d_ill;
            end
        end
    end

endmodule
